// File: rtl/run_detector_pkg.sv
// Shared lab constants for the run detector: output-mode encodings and the
// parameter legality rule used by every instance.
package run_detector_pkg;

  typedef enum logic {
    MODE_MOORE = 1'b0,
    MODE_MEALY = 1'b1
  } mode_e;

  localparam int RUN_LEN_MIN = 2;
  localparam int RUN_LEN_MAX = 15;

  // A run length is usable when it sits in the supported range and the
  // run-length register is wide enough to hold the saturated value.
  function automatic bit run_len_params_ok(input int run_len, input int len_w);
    return (run_len >= RUN_LEN_MIN) && (run_len <= RUN_LEN_MAX) &&
           (len_w >= $clog2(run_len + 1));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Count events, stick at all-ones, and drop an event that meets a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/run_detector.sv
// Serial run detector: tracks the current run of identical bits, flags a run
// of RUN_LEN bits in Moore or Mealy form, and counts completed 0/1 runs.
module run_detector
  import run_detector_pkg::*;
#(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in,
  input  logic             mode,
  input  logic             clr_cnt,
  output logic             out,
  output logic             run_bit,
  output logic [LEN_W-1:0] run_len,
  output logic [CNT_W-1:0] zero_runs,
  output logic [CNT_W-1:0] one_runs
);

  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(RUN_LEN);
  localparam logic [LEN_W-1:0] LEN_PRE = LEN_W'(RUN_LEN - 1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  if (!run_len_params_ok(RUN_LEN, LEN_W)) begin : g_bad_params
    $error("run_detector: RUN_LEN must be 2..15 and LEN_W >= clog2(RUN_LEN+1)");
  end

  logic             run_bit_nxt;
  logic [LEN_W-1:0] run_len_nxt;
  logic             match;
  logic             run_event;

  // A bit continues the run only once something has been accepted.
  assign match     = (run_len != '0) && (in == run_bit);
  // The event fires on the single bit that completes the run, never after.
  assign run_event = in_valid && match && (run_len == LEN_PRE);

  // Run state register; reset discards any partial run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_bit <= 1'b0;
      run_len <= '0;
    end else begin
      run_bit <= run_bit_nxt;
      run_len <= run_len_nxt;
    end
  end

  // Next run state: extend and saturate on a match, restart on a new bit.
  always_comb begin
    run_bit_nxt = run_bit;
    run_len_nxt = run_len;
    if (in_valid) begin
      if (match) begin
        if (run_len != LEN_SAT) begin
          run_len_nxt = run_len + LEN_ONE;
        end
      end else begin
        run_bit_nxt = in;
        run_len_nxt = LEN_ONE;
      end
    end
  end

  // Output decode: Moore looks at the register, Mealy anticipates the next bit.
  always_comb begin
    out = 1'b0;
    case (mode_e'(mode))
      MODE_MEALY: out = in_valid && (in == run_bit) && (run_len >= LEN_PRE);
      default:    out = (run_len == LEN_SAT);
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_zero_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (run_event && !run_bit),
    .clr   (clr_cnt),
    .count (zero_runs)
  );

  sat_counter #(.CNT_W(CNT_W)) u_one_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (run_event && run_bit),
    .clr   (clr_cnt),
    .count (one_runs)
  );

endmodule
